// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/regfile.sv
// 32-entry register file: two combinational read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes.
module regfile #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             we3,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2,
    input  logic [4:0]       a3,
    input  logic [WIDTH-1:0] wd3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] rf_q [32];
    logic [WIDTH-1:0] rf_d [32];

    always_comb begin
        rf_d = rf_q;
        if (we3 && (a3 != 5'd0)) begin
            rf_d[a3] = wd3;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rd1 = (a1 == 5'd0) ? '0 : rf_q[a1];
    assign rd2 = (a2 == 5'd0) ? '0 : rf_q[a2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, register file, ALU and operand muxes.
// Driven each cycle by the main control FSM's control word.
module mc_datapath
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcwrite,
    input  logic             branch,
    input  logic             iord,
    input  logic             irwrite,
    input  logic             regdst,
    input  logic             regwrite,
    input  logic             memtoreg,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic [1:0]       pcsrc,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] readdata,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             zero
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;

    logic [WIDTH-1:0] rd1, rd2, wd3;
    logic [WIDTH-1:0] signimm, srca, srcb, aluresult, pcnext;
    logic [4:0]       a3;
    logic             pcen;

    assign signimm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign srca    = alusrca ? a_q : pc_q;

    always_comb begin
        srcb = b_q;
        case (alusrcb)
            SRCB_REG:   srcb = b_q;
            SRCB_FOUR:  srcb = WIDTH'(4);
            SRCB_IMM:   srcb = signimm;
            SRCB_IMMSH: srcb = {signimm[WIDTH-3:0], 2'b00};
            default:    srcb = b_q;
        endcase
    end

    // Arithmetic wraps silently; unlisted codes produce zero.
    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ALU_ADD: aluresult = srca + srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);
    assign pcen = pcwrite | (branch & zero);

    always_comb begin
        pcnext = pc_q;
        case (pcsrc)
            PC_ALU:    pcnext = aluresult;
            PC_ALUOUT: pcnext = aluout_q;
            PC_JUMP:   pcnext = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
            default:   pcnext = pc_q;
        endcase
    end

    always_comb begin
        pc_d     = pcen ? pcnext : pc_q;
        ir_d     = irwrite ? readdata : ir_q;
        mdr_d    = readdata;
        a_d      = rd1;
        b_d      = rd2;
        aluout_d = aluresult;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    assign a3  = regdst ? ir_q[15:11] : ir_q[20:16];
    assign wd3 = memtoreg ? mdr_q : aluout_q;

    // A reset edge aborts the instruction, including any pending write-back.
    regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk (clk),
        .we3 (regwrite & reset),
        .a1  (ir_q[25:21]),
        .a2  (ir_q[20:16]),
        .a3  (a3),
        .wd3 (wd3),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign adr       = iord ? aluout_q : pc_q;
    assign writedata = b_q;
    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle MIPS datapath: architectural and non-architectural state registers (PC, IR, MDR, A, B, ALUOut), a 32×32 register file, the ALU and the operand/result muxes. It sits directly downstream of the main control FSM and consumes its per-state control word each cycle. It returns `op`, `funct` and `zero` to the controller and drives the unified instruction/data memory port.

## Interface
Parameters:
- `WIDTH`, 32: datapath word width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on the rising edge of `clk`.
- `pcwrite, branch, iord, irwrite, regdst, regwrite, memtoreg, alusrca`  in  1 each  control from the FSM.
- `alusrcb`  in  2  ALU B-operand select.
- `pcsrc`  in  2  next-PC select.
- `alucontrol`  in  3  ALU operation, from the ALU decoder.
- `readdata`  in  32  memory read data, combinational for the current `adr`.
- `adr`  out  32  memory address.
- `writedata`  out  32  store data; always equals the B register.
- `op`  out  6  IR[31:26].
- `funct`  out  6  IR[5:0].
- `zero`  out  1  ALU result == 0, combinational.

## Operation
- `pcen = pcwrite | (branch & zero)`. PC loads the next-PC value only when `pcen` is 1.
- Next PC by `pcsrc`:
  - 00: ALU result.
  - 01: ALUOut.
  - 10: `{PC[31:28], IR[25:0], 2'b00}`.
  - 11: hold PC.
- `adr = iord ? ALUOut : PC`.
- IR loads `readdata` when `irwrite` is 1, otherwise holds.
- MDR loads `readdata` every cycle.
- A, B and ALUOut load every cycle:
  - A ← rf[IR[25:21]].
  - B ← rf[IR[20:16]].
  - ALUOut ← ALU result.
- `signimm` = sign-extended IR[15:0].
- SrcA = `alusrca ? A : PC`.
- SrcB by `alusrcb`: 00 B, 01 32'd4, 10 `signimm`, 11 `signimm << 2`.
- ALU by `alucontrol`:
  - 010 add, 110 sub, 000 and, 001 or, 111 slt (signed compare, result 0 or 1).
  - Any other code yields 0.
  - Arithmetic is modulo 2^32; overflow is ignored with no trap.
- Register-file write port:
  - Address = `regdst ? IR[15:11] : IR[20:16]`.
  - Data = `memtoreg ? MDR : ALUOut`.
  - Written on the clock edge when `regwrite` is 1.
- Register 0 always reads 0; writes to it are discarded.

## Timing
- Reset (`reset` = 0 at an edge):
  - PC ← `RESET_PC`; IR, MDR, A, B, ALUOut ← 0.
  - Register-file contents are not reset.
- Resulting output values after reset: `adr` = `RESET_PC` when `iord` = 0, otherwise 0; `writedata` = 0; `op` = 0; `funct` = 0.
- Reset mid-instruction aborts it. The next non-reset edge behaves as the first cycle after reset; partial register-file writes never occur.
- Memory reads are combinational with zero added latency: `readdata` for the current `adr` is captured into IR/MDR at the same edge.
- Register-file read is combinational and write is synchronous. A same-cycle read and write of the same register returns the old value, which is what A/B capture.
- `op`, `funct` and `zero` are valid in the same cycle as the state that uses them.
- Branch: taken-branch `pcen` is evaluated from `zero` in the same cycle.
- PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode and funct constants.
  - `alusrcb` encodings: SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMMSH.
  - `pcsrc` encodings: PC_ALU, PC_ALUOUT, PC_JUMP.
  - `alucontrol` encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
- One sub-module is natural: `regfile` (2 read ports, 1 write port, 32×`WIDTH`, r0 hardwired to 0).
- The ALU, muxes and state registers stay inline.

## Test plan
- Reset, then fetch with controller fetch controls (`pcwrite`, `irwrite`, `alusrcb` = 01, `pcsrc` = 00) and `readdata` = 32'h2008_0005 → after one edge: IR = 32'h2008_0005, PC = 4, `op` = 6'b001000.
- addi r8 = r0 + 5 via ALU then writeback (`regdst` = 0, `memtoreg` = 0) → rf[8] = 5. A later read of r8 into A gives 5. A write to r0 leaves a read of 0.
- beq with A = B = 7, `alucontrol` = 110, `branch` = 1, `pcsrc` = 01, ALUOut = 32'h40 → `zero` = 1, PC = 32'h40. With A = 7, B = 8 → PC is unchanged.
- jump with PC = 32'h1000_0004 and IR[25:0] = 26'h000_0010, `pcsrc` = 10, `pcwrite` = 1 → PC = 32'h1000_0040.
- slt with A = 32'hFFFF_FFFF, B = 1, `alucontrol` = 111 → ALUOut = 1. PC = 32'hFFFF_FFFC plus a fetch → PC = 0.
- lw with ALUOut = 32'h80, `iord` = 1 → `adr` = 32'h80. Then `reset` = 0 mid-sequence → next cycle PC = 0, IR = 0, and rf[8] is still 5.
